// File: rtl/logic_unit_pipe.sv
// WIDTH-generic, op-selectable bitwise logic unit with an accumulator operand,
// registered zero/ones/parity flags and a STAGES-deep valid/ready pipeline.
module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones,
  output logic             parity
);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             ones;
    logic             parity;
  } res_t;

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0]       sel,
                                                 input logic [WIDTH-1:0] opa,
                                                 input logic [WIDTH-1:0] opb);
    logic [WIDTH-1:0] r;
    case (sel)
      3'b000:  r = opa & opb;
      3'b001:  r = opa | opb;
      3'b010:  r = opa ^ opb;
      3'b011:  r = ~(opa & opb);
      3'b100:  r = ~(opa | opb);
      3'b101:  r = ~(opa ^ opb);
      3'b110:  r = ~opa;
      default: r = opb;
    endcase
    return r;
  endfunction

  function automatic res_t make_res(input logic [WIDTH-1:0] r);
    res_t s;
    s.y      = r;
    s.zero   = ~|r;
    s.ones   = &r;
    s.parity = ^r;
    return s;
  endfunction

  logic [STAGES-1:0] vld_q;
  res_t              data_q [STAGES];
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  op_a, result;
  res_t              res_in;
  logic              accept;

  // A stage may advance when it or any later stage is empty, or the consumer takes the head.
  always_comb begin
    logic chain;
    adv   = '0;
    chain = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      chain  = chain || !vld_q[i];
      adv[i] = chain;
    end
  end

  assign in_ready = adv[0];
  assign accept   = in_valid && adv[0];

  always_comb begin
    op_a   = acc_en ? (acc_clr ? '0 : acc_q) : a;
    result = logic_op(op, op_a, b);
    res_in = make_res(result);
    acc_d  = acc_q;
    if (accept && acc_en) begin
      acc_d = result;
    end else if (acc_clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      acc_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      acc_q <= acc_d;
      // stage 0 captures the freshly computed result and flags
      if (adv[0]) begin
        vld_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= res_in;
        end
      end
      // stages 1..STAGES-1 shift; data is only moved with a valid so bubbles keep y stable
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i]) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) begin
            data_q[i] <= data_q[i-1];
          end
        end
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign y         = data_q[STAGES-1].y;
  assign zero      = data_q[STAGES-1].zero;
  assign ones      = data_q[STAGES-1].ones;
  assign parity    = data_q[STAGES-1].parity;

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined bitwise logic unit with valid/ready flow control, a result accumulator and registered result flags. It extends the team's fixed-width combinational gate primitives (2/3/4/5-input AND/OR, 4- and 32-bit INV/AND/OR/XOR/XNOR, NOR) into one WIDTH-generic, op-selectable datapath block with backpressure. It sits between an operand source and a result consumer in the ALU/datapath.

## Interface
- WIDTH, 32, operand/result width in bits (≥1)
- STAGES, 2, pipeline register stages from input to output (1..4)

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand transaction present
- in_ready  output  1  block accepts a transaction this cycle
- op  input  3  operation select (below)
- acc_en  input  1  operand A is taken from the accumulator; accumulator is updated with the result
- acc_clr  input  1  clear accumulator
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result present
- out_ready  input  1  consumer takes the result this cycle
- y  output  WIDTH  result
- zero  output  1  y == 0
- ones  output  1  y is all ones
- parity  output  1  XOR-reduction of y

## Operation
- Accept: in_valid && in_ready on a rising edge. Retire: out_valid && out_ready.
- Effective A: if acc_en, then (acc_clr ? 0 : acc); else a.
- op encoding: 000 A&B, 001 A|B, 010 A^B, 011 ~(A&B), 100 ~(A|B), 101 ~(A^B), 110 ~A, 111 B.
- Result and flags are computed combinationally at the input and captured into stage 0. Each stage carries {valid, y, zero, ones, parity}. y, zero, ones and parity are driven from stage STAGES-1.
- Accumulator acc (WIDTH bits, internal, resets to 0):
  - On accept with acc_en=1: acc <= result.
  - Otherwise, if acc_clr=1: acc <= 0. acc_clr is honoured in any cycle; it needs no accept.
  - Otherwise acc holds.
  - Accept with acc_en=0 leaves acc unchanged unless acc_clr is also 1.
- Pipeline flow:
  - Stage i advances when it is empty or stage i+1 advances. The last stage advances when it is empty or out_ready=1.
  - in_ready = !valid[0] || advance[0], combinational from out_ready through the stage valids.
  - Throughput is one transaction per cycle while out_ready=1. Results are never reordered, dropped or duplicated.
- Stall: while out_valid=1 and out_ready=0, y and the flags hold stable. The pipeline holds at most STAGES transactions.
- Reset (reset_n low, at any time, including mid-stream): all valids 0, all stage data 0, acc 0. Outputs: out_valid=0, y=0, zero=0, ones=0, parity=0. in_ready=1 once reset_n is high. In-flight transactions are discarded.

## Timing
- Latency: a transaction accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. visible in the cycle following that edge. For STAGES=1 it is visible in the cycle after the accept edge.
- Accumulator chaining: a back-to-back accept with acc_en uses the acc value written at the previous edge. Consecutive accumulate ops therefore need no bubbles.
- Simultaneous accept and retire when full: allowed. in_ready=1 in that cycle because the pipeline shifts.
- The only combinational in-to-out path is out_ready → in_ready. All other outputs are registered.
- Reset assertion clears asynchronously. Reset release is synchronised by the enclosing design.

## Test plan
- AND: WIDTH=32, STAGES=2, op=000, a=F0F0F0F0, b=FF00FF00, out_ready=1 -> y=F000F000 with out_valid=1 two cycles after the accept; zero=0, ones=0, parity=0.
- NOR and NOT flags: op=100, a=FFFFFFFF, b=0 -> y=0, zero=1, ones=0, parity=0. Then op=110, a=0 -> y=FFFFFFFF, ones=1, zero=0, parity=0.
- Backpressure: out_ready=0, in_valid=1 with op=111 and b=1,2,3 -> only 1 and 2 accepted, in_ready=0 while full, y=1 held stable. Raise out_ready -> y sequence 1,2,3, with 3 accepted the same cycle 1 retires.
- Accumulate chain:
  - op=010, acc_en=1, acc_clr=1, b=1 -> y=1.
  - Then op=010, acc_en=1, b=3 -> y=2.
  - Then op=001, acc_en=1, b=8 -> y=A. Issued back-to-back.
  - Then acc_clr alone with no accept, followed by op=001, acc_en=1, b=5 -> y=5.
- Reset mid-stream: two transactions in flight, pull reset_n low -> out_valid=0, y=0 and all flags 0 immediately, before the next clock edge. After release, op=001, acc_en=1, b=0 -> y=0, confirming acc was cleared.
- STAGES=1, WIDTH=8: op=101, a=0F, b=3C -> y=CC one cycle after the accept, parity=0. Continuous stream with out_ready toggling every cycle -> no loss, order preserved.
